// File: rtl/mc_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_if
// Purpose  : Control bundle between the multicycle controller and its datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic [1:0] memtoreg;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output pcen, irwrite, memwrite, regwrite, iord, alusrca, alusrcb,
               aluop, pcsrc, regdst, memtoreg, state, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pcen, irwrite, memwrite, regwrite, iord, alusrca, alusrcb,
               aluop, pcsrc, regdst, memtoreg, state, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Purpose  : Moore FSM sequencing a multicycle CPU datapath (ADD/LOAD/STORE/BEQ/JAL).
// Revision : 1.0 - initial release
// ============================================================================
module mc_controller (
    input  logic  clk,
    input  logic  reset,
    mc_if.master  bus
);

    localparam logic [3:0] C_OP_ADD   = 4'b0000;
    localparam logic [3:0] C_OP_STORE = 4'b1001;
    localparam logic [3:0] C_OP_LOAD  = 4'b1010;
    localparam logic [3:0] C_OP_BEQ   = 4'b1011;
    localparam logic [3:0] C_OP_JAL   = 4'b1101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JAL    = 4'd9
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   w_legal;
    logic   w_pcwrite;
    logic   w_branch;

    assign w_legal = (bus.opcode == C_OP_ADD)  || (bus.opcode == C_OP_STORE) ||
                     (bus.opcode == C_OP_LOAD) || (bus.opcode == C_OP_BEQ)   ||
                     (bus.opcode == C_OP_JAL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= (r_state == S_DECODE) && !w_legal;
        end
    end

    // Unused encodings 10-15 fall through the default back to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    C_OP_ADD:              w_next = S_EXEC;
                    C_OP_LOAD, C_OP_STORE: w_next = S_MEMADR;
                    C_OP_BEQ:              w_next = S_BRANCH;
                    C_OP_JAL:              w_next = S_JAL;
                    default:               w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (bus.opcode == C_OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JAL:    w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        bus.irwrite  = 1'b0;
        bus.memwrite = 1'b0;
        bus.regwrite = 1'b0;
        bus.iord     = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.aluop    = 2'b00;
        bus.pcsrc    = 2'b00;
        bus.regdst   = 1'b0;
        bus.memtoreg = 2'b00;
        case (r_state)
            S_FETCH: begin
                bus.irwrite = bus.mem_ready;
                w_pcwrite   = bus.mem_ready;
                bus.alusrcb = 2'b01;
            end
            S_DECODE: bus.alusrcb = 2'b11;
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD:  bus.iord = 1'b1;
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 2'b01;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_EXEC: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            S_ALUWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                w_branch    = 1'b1;
            end
            S_JAL: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 2'b10;
                bus.pcsrc    = 2'b10;
                w_pcwrite    = 1'b1;
            end
            default: ;
        endcase
        bus.pcen = w_pcwrite | (w_branch & bus.zero);
        // Reset must silence FETCH's mem_ready-driven enables without waiting for clk.
        if (!reset) begin
            bus.pcen     = 1'b0;
            bus.irwrite  = 1'b0;
            bus.memwrite = 1'b0;
            bus.regwrite = 1'b0;
            bus.iord     = 1'b0;
            bus.alusrca  = 1'b0;
            bus.alusrcb  = 2'b00;
            bus.aluop    = 2'b00;
            bus.pcsrc    = 2'b00;
            bus.regdst   = 1'b0;
            bus.memtoreg = 2'b00;
        end
    end

    assign bus.state   = r_state;
    assign bus.illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_controller
// Purpose  : Directed self-checking bench for mc_controller with a sequence model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    mc_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: each instruction is a fixed list of state codes; FETCH, MEMRD, MEMWR repeat while mem_ready=0.
    int         m_pos = 0;
    logic [3:0] m_op  = 4'h0;
    logic       m_ill = 1'b0;

    function automatic int seq_len(input logic [3:0] op);
        case (op)
            4'h0, 4'h9: return 4;
            4'hA:       return 5;
            4'hB, 4'hD: return 3;
            default:    return 2;
        endcase
    endfunction

    function automatic logic [3:0] seq_at(input logic [3:0] op, input int pos);
        logic [23:0] s;
        case (op)
            4'h0:    s = 24'h016700;
            4'h9:    s = 24'h012500;
            4'hA:    s = 24'h012340;
            4'hB:    s = 24'h018000;
            4'hD:    s = 24'h019000;
            default: s = 24'h010000;
        endcase
        if (pos < 0 || pos > 5) return 4'hF;
        return s[23 - 4*pos -: 4];
    endfunction

    function automatic bit waits(input logic [3:0] st, input logic mr);
        return (st == 4'd0 || st == 4'd3 || st == 4'd5) && !mr;
    endfunction

    function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic mr, input logic z,
                                            input logic ill, input logic rstn);
        logic pcw, br, irw, mw, rw, iord, asa, rdst;
        logic [1:0] asb, aop, psrc, mtr;
        {pcw, br, irw, mw, rw, iord, asa, rdst} = 8'h00;
        {asb, aop, psrc, mtr} = 8'h00;
        case (st)
            4'd0: begin irw = mr; pcw = mr; asb = 2'd1; end
            4'd1: asb = 2'd3;
            4'd2: begin asa = 1'b1; asb = 2'd2; end
            4'd3: iord = 1'b1;
            4'd4: begin rw = 1'b1; mtr = 2'd1; end
            4'd5: begin iord = 1'b1; mw = 1'b1; end
            4'd6: begin asa = 1'b1; aop = 2'd2; end
            4'd7: begin rw = 1'b1; rdst = 1'b1; end
            4'd8: begin asa = 1'b1; aop = 2'd1; br = 1'b1; psrc = 2'd1; end
            4'd9: begin rw = 1'b1; mtr = 2'd2; pcw = 1'b1; psrc = 2'd2; end
            default: ;
        endcase
        if (!rstn) return 20'h0;
        return {pcw | (br & z), irw, mw, rw, iord, asa, asb, aop, psrc, rdst, mtr, ill, st};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pos <= 0;
            m_ill <= 1'b0;
        end else begin
            m_ill <= (m_pos == 1) && (seq_len(m_op) == 2);
            if (!waits(seq_at(m_op, m_pos), bus.mem_ready))
                m_pos <= (m_pos + 1 >= seq_len(m_op)) ? 0 : m_pos + 1;
            if (m_pos == 0 && bus.mem_ready)
                m_op <= bus.opcode;
        end
    end

    initial begin
        logic [19:0] act, expv;
        forever begin
            @(negedge clk);
            act  = {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.iord, bus.alusrca,
                    bus.alusrcb, bus.aluop, bus.pcsrc, bus.regdst, bus.memtoreg, bus.illegal, bus.state};
            expv = exp_vec(seq_at(m_op, m_pos), bus.mem_ready, bus.zero, m_ill, reset);
            checks++;
            if (act !== expv) begin
                fails++;
                $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, act, expv);
            end
            checks++;
            if ($countones({bus.irwrite, bus.memwrite, bus.regwrite}) > 1) begin
                fails++;
                $display("FAIL write_exclusive t=%0t actual=%b required=at most one",
                         $time, {bus.irwrite, bus.memwrite, bus.regwrite});
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Entered and left at posedge+1 with the DUT in FETCH.
    task automatic run(input logic [3:0] op, input int fstall, input int mstall, input logic z,
                       output int len, output logic [39:0] tr,
                       output int n_pc, output int n_mw, output int n_rw);
        int fc = fstall;
        int mc = mstall;
        bit left = 1'b0;
        bit done = 1'b0;
        logic [3:0] cur;
        len = 0; tr = 40'h0; n_pc = 0; n_mw = 0; n_rw = 0;
        bus.opcode = op;
        bus.zero   = z;
        for (int g = 0; g < 40; g++) begin
            cur = seq_at(m_op, m_pos);
            if (m_pos == 0 && fc > 0) begin
                bus.mem_ready = 1'b0; fc--;
            end else if ((cur == 4'd3 || cur == 4'd5) && mc > 0) begin
                bus.mem_ready = 1'b0; mc--;
            end else begin
                bus.mem_ready = 1'b1;
            end
            #1;
            tr   = {tr[35:0], bus.state};
            n_pc += int'(bus.pcen);
            n_mw += int'(bus.memwrite);
            n_rw += int'(bus.regwrite);
            len++;
            @(posedge clk); #1;
            if (m_pos != 0) left = 1'b1;
            else if (left) begin done = 1'b1; break; end
        end
        if (!done) begin
            fails++;
            $display("FAIL run_timeout op=%h actual=no return to FETCH required=return", op);
        end
    endtask

    initial begin
        int len, n_pc, n_mw, n_rw;
        logic [39:0] tr;
        bus.opcode = 4'h0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state",   {60'h0, bus.state}, 64'h0);
        chk("reset_enables", {59'h0, bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.illegal}, 64'h0);
        chk("reset_selects", {bus.iord, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.regdst, bus.memtoreg}, 64'h0);
        reset = 1'b1;

        run(4'h0, 0, 0, 1'b0, len, tr, n_pc, n_mw, n_rw);   // ADD 0x02a0
        chk("add_len", len, 4); chk("add_trace", tr, 40'h0167); chk("add_pcen", n_pc, 1); chk("add_rw", n_rw, 1);

        run(4'h0, 2, 0, 1'b0, len, tr, n_pc, n_mw, n_rw);
        chk("add_fetch_stall_len", len, 6); chk("add_fetch_stall_pcen", n_pc, 1);

        run(4'hA, 0, 3, 1'b0, len, tr, n_pc, n_mw, n_rw);   // LOAD 0xa281
        chk("load_stall_len", len, 8); chk("load_stall_trace", tr, 40'h01233334); chk("load_rw", n_rw, 1);

        run(4'hA, 0, 0, 1'b0, len, tr, n_pc, n_mw, n_rw);
        chk("load_len", len, 5);

        run(4'h9, 0, 2, 1'b0, len, tr, n_pc, n_mw, n_rw);   // STORE 0x9c4c
        chk("store_len", len, 6); chk("store_trace", tr, 40'h012555);
        chk("store_mw", n_mw, 3); chk("store_rw", n_rw, 0);

        run(4'h9, 0, 0, 1'b0, len, tr, n_pc, n_mw, n_rw);
        chk("store_nostall_len", len, 4);

        run(4'hB, 0, 0, 1'b1, len, tr, n_pc, n_mw, n_rw);   // BEQ 0xb73c taken
        chk("beq_taken_len", len, 3); chk("beq_taken_pcen", n_pc, 2);
        run(4'hB, 0, 0, 1'b0, len, tr, n_pc, n_mw, n_rw);   // not taken
        chk("beq_not_taken_pcen", n_pc, 1);

        run(4'hD, 0, 0, 1'b0, len, tr, n_pc, n_mw, n_rw);   // JAL 0xdff9
        chk("jal_len", len, 3); chk("jal_trace", tr, 40'h019); chk("jal_pcen", n_pc, 2); chk("jal_rw", n_rw, 1);

        run(4'h3, 0, 0, 1'b0, len, tr, n_pc, n_mw, n_rw);
        chk("illegal3_len", len, 2); chk("illegal3_pulse", {63'h0, bus.illegal}, 64'h1);

        run(4'hF, 0, 0, 1'b0, len, tr, n_pc, n_mw, n_rw);
        chk("illegalF_len", len, 2); chk("illegalF_pulse", {63'h0, bus.illegal}, 64'h1);
        chk("illegalF_state", {60'h0, bus.state}, 64'h0);

        // LOAD stalled in MEMRD, then asynchronous reset between edges.
        bus.opcode = 4'hA; bus.mem_ready = 1'b1;
        for (int g = 0; g < 10 && m_pos != 3; g++) begin
            @(posedge clk); #1;
        end
        chk("reach_memrd", m_pos, 3);
        bus.mem_ready = 1'b0;
        @(posedge clk); #3;
        chk("memrd_held", {60'h0, bus.state}, 64'h3);
        reset = 1'b0;
        #1;
        chk("async_reset_state", {60'h0, bus.state}, 64'h0);
        chk("async_reset_enables", {59'h0, bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.illegal}, 64'h0);
        chk("async_reset_selects", {bus.iord, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.regdst, bus.memtoreg}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1; bus.opcode = 4'h0;
        reset = 1'b1;

        run(4'h0, 0, 0, 1'b0, len, tr, n_pc, n_mw, n_rw);
        chk("add_after_reset_len", len, 4); chk("add_after_reset_trace", tr, 40'h0167);

        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
